// File: rtl/stepper_controller.sv
// Control FSM for the stepper-motor application-specific processor.
// Turns the datapath's decoded instruction flags and status bits into every
// datapath control strobe: fetch/decode, single-cycle ALU and branch ops,
// timed pauses and multi-step relative moves driven by the temp register.
// Outputs are Mealy (state + inputs); every output defaults to 0.

module stepper_controller #(
  parameter int HS_REPEAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       br,
  input  logic       brz,
  input  logic       addi,
  input  logic       subi,
  input  logic       sr0,
  input  logic       srh0,
  input  logic       clr,
  input  logic       mov,
  input  logic       mova,
  input  logic       movr,
  input  logic       movrhs,
  input  logic       pause,
  input  logic       delay_done,
  input  logic       temp_is_positive,
  input  logic       temp_is_negative,
  input  logic       temp_is_zero,
  input  logic       register0_is_zero,
  output logic       write_reg_file,
  output logic       result_mux_select,
  output logic [1:0] op1_mux_select,
  output logic [1:0] op2_mux_select,
  output logic       start_delay_counter,
  output logic       enable_delay_counter,
  output logic       commit_branch,
  output logic       increment_pc,
  output logic       alu_add_sub,
  output logic       alu_set_low,
  output logic       alu_set_high,
  output logic       load_temp,
  output logic       increment_temp,
  output logic       decrement_temp,
  output logic [1:0] select_immediate,
  output logic [1:0] select_write_address
);

  // Pass counter is wide enough to hold HS_REPEAT itself, so the limit
  // comparison below never truncates.
  localparam int             PW       = $clog2(HS_REPEAT + 1);
  localparam logic [PW:0]    HS_LIMIT = (PW + 1)'(HS_REPEAT);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_P_START = 3'd2,
    ST_P_WAIT  = 3'd3,
    ST_M_CHECK = 3'd4,
    ST_M_START = 3'd5,
    ST_M_WAIT  = 3'd6
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            hs_r;
  logic            hs_nxt_s;
  logic [PW-1:0]   pass_cnt_r;
  logic [PW-1:0]   pass_cnt_nxt_s;
  logic            pass_more_s;
  logic            take_branch_s;

  // Another delay pass is owed when the next pass index is still below the limit.
  assign pass_more_s   = ({1'b0, pass_cnt_r} + {{PW{1'b0}}, 1'b1}) < HS_LIMIT;
  // br always branches; brz only when R0 is zero (br has priority anyway).
  assign take_branch_s = br | (brz & register0_is_zero);

  // State, high-speed flag and pass counter registers; reset lands in FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_FETCH;
      hs_r       <= 1'b0;
      pass_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      hs_r       <= hs_nxt_s;
      pass_cnt_r <= pass_cnt_nxt_s;
    end
  end

  // Next-state and Mealy output decode; all strobes default low.
  always_comb begin
    state_nxt_s          = state_r;
    hs_nxt_s             = hs_r;
    pass_cnt_nxt_s       = pass_cnt_r;
    write_reg_file       = 1'b0;
    result_mux_select    = 1'b0;
    op1_mux_select       = 2'b00;
    op2_mux_select       = 2'b00;
    start_delay_counter  = 1'b0;
    enable_delay_counter = 1'b0;
    commit_branch        = 1'b0;
    increment_pc         = 1'b0;
    alu_add_sub          = 1'b0;
    alu_set_low          = 1'b0;
    alu_set_high         = 1'b0;
    load_temp            = 1'b0;
    increment_temp       = 1'b0;
    decrement_temp       = 1'b0;
    select_immediate     = 2'b00;
    select_write_address = 2'b00;

    case (state_r)
      ST_FETCH: begin
        // Instruction ROM is synchronous: give it a cycle after any PC change.
        state_nxt_s = ST_DECODE;
      end

      ST_DECODE: begin
        state_nxt_s = ST_FETCH;
        if (take_branch_s) begin
          op1_mux_select   = 2'b00;
          op2_mux_select   = 2'b01;
          select_immediate = 2'b00;
          commit_branch    = 1'b1;
        end else if (brz) begin
          increment_pc = 1'b1;
        end else if (addi || subi) begin
          op1_mux_select       = 2'b01;
          op2_mux_select       = 2'b01;
          select_immediate     = 2'b01;
          alu_add_sub          = subi;
          write_reg_file       = 1'b1;
          select_write_address = 2'b00;
          increment_pc         = 1'b1;
        end else if (sr0 || srh0) begin
          op1_mux_select       = 2'b10;
          op2_mux_select       = 2'b01;
          select_immediate     = 2'b10;
          alu_set_low          = sr0;
          alu_set_high         = ~sr0;
          write_reg_file       = 1'b1;
          select_write_address = 2'b10;
          increment_pc         = 1'b1;
        end else if (clr) begin
          op1_mux_select       = 2'b01;
          op2_mux_select       = 2'b10;
          alu_set_low          = 1'b1;
          alu_set_high         = 1'b1;
          write_reg_file       = 1'b1;
          select_write_address = 2'b00;
          increment_pc         = 1'b1;
        end else if (mov) begin
          op1_mux_select       = 2'b01;
          op2_mux_select       = 2'b10;
          write_reg_file       = 1'b1;
          select_write_address = 2'b01;
          increment_pc         = 1'b1;
        end else if (mova) begin
          // Absolute move: position <- Rs, then settle through a pause.
          op1_mux_select       = 2'b01;
          op2_mux_select       = 2'b10;
          write_reg_file       = 1'b1;
          select_write_address = 2'b11;
          state_nxt_s          = ST_P_START;
        end else if (movr || movrhs) begin
          load_temp   = 1'b1;
          hs_nxt_s    = movrhs;
          state_nxt_s = ST_M_CHECK;
        end else if (pause) begin
          state_nxt_s = ST_P_START;
        end else begin
          increment_pc = 1'b1;
        end
      end

      ST_P_START: begin
        start_delay_counter = 1'b1;
        state_nxt_s         = ST_P_WAIT;
      end

      ST_P_WAIT: begin
        enable_delay_counter = 1'b1;
        if (delay_done) begin
          increment_pc = 1'b1;
          state_nxt_s  = ST_FETCH;
        end else begin
          state_nxt_s = ST_P_WAIT;
        end
      end

      ST_M_CHECK: begin
        if (temp_is_zero) begin
          increment_pc = 1'b1;
          state_nxt_s  = ST_FETCH;
        end else if (temp_is_positive || temp_is_negative) begin
          // One step toward zero: position +/- 1, temp -/+ 1.
          op1_mux_select       = 2'b11;
          op2_mux_select       = 2'b11;
          alu_add_sub          = temp_is_negative;
          write_reg_file       = 1'b1;
          select_write_address = 2'b11;
          decrement_temp       = ~temp_is_negative;
          increment_temp       = temp_is_negative;
          pass_cnt_nxt_s       = '0;
          state_nxt_s          = ST_M_START;
        end else begin
          // No sign flag at all: treat as finished rather than stall.
          increment_pc = 1'b1;
          state_nxt_s  = ST_FETCH;
        end
      end

      ST_M_START: begin
        start_delay_counter = 1'b1;
        state_nxt_s         = ST_M_WAIT;
      end

      ST_M_WAIT: begin
        enable_delay_counter = 1'b1;
        if (delay_done) begin
          if (hs_r && pass_more_s) begin
            pass_cnt_nxt_s = pass_cnt_r + {{(PW-1){1'b0}}, 1'b1};
            state_nxt_s    = ST_M_START;
          end else begin
            state_nxt_s = ST_M_CHECK;
          end
        end else begin
          state_nxt_s = ST_M_WAIT;
        end
      end

      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_stepper_controller.sv
// Self-checking bench for stepper_controller: scenario generators build a
// cycle-by-cycle table of inputs and expected outputs from the instruction
// rules; one compare process checks every queued cycle and the pinned counts.
`timescale 1ns/1ps
module tb_stepper_controller;

  localparam int HS = 2;

  typedef struct packed {
    logic br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause;
  } flags_t;

  typedef struct packed {
    logic       wr;
    logic       rms;
    logic [1:0] op1;
    logic [1:0] op2;
    logic       start;
    logic       enable;
    logic       commit;
    logic       inc_pc;
    logic       add_sub;
    logic       set_low;
    logic       set_high;
    logic       load_temp;
    logic       inc_temp;
    logic       dec_temp;
    logic [1:0] sel_imm;
    logic [1:0] wr_addr;
  } outs_t;

  typedef struct {
    string  name;
    logic   rn;
    logic   rst_mid;
    flags_t f;
    logic   dd;
    logic [2:0] t;      // {zero, positive, negative}
    logic   r0z;
    outs_t  e;
    logic   clr;
    logic   chk;
    int     exp_starts;
    int     exp_writes;
    int     mdl_starts;
    int     mdl_writes;
  } entry_t;

  localparam flags_t F_NONE   = 12'h000;
  localparam flags_t F_BR     = 12'h800;
  localparam flags_t F_BRZ    = 12'h400;
  localparam flags_t F_ADDI   = 12'h200;
  localparam flags_t F_SUBI   = 12'h100;
  localparam flags_t F_SR0    = 12'h080;
  localparam flags_t F_SRH0   = 12'h040;
  localparam flags_t F_CLR    = 12'h020;
  localparam flags_t F_MOV    = 12'h010;
  localparam flags_t F_MOVA   = 12'h008;
  localparam flags_t F_MOVR   = 12'h004;
  localparam flags_t F_MOVRHS = 12'h002;
  localparam flags_t F_PAUSE  = 12'h001;

  logic clk = 1'b0;
  logic reset_n;
  flags_t fl;
  logic dd, tz, tp, tn, r0z;
  logic write_reg_file, result_mux_select, start_delay_counter, enable_delay_counter;
  logic commit_branch, increment_pc, alu_add_sub, alu_set_low, alu_set_high;
  logic load_temp, increment_temp, decrement_temp;
  logic [1:0] op1_mux_select, op2_mux_select, select_immediate, select_write_address;
  outs_t dut_o;

  entry_t q[$];
  entry_t cur;
  logic   cur_valid = 1'b0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     tally_starts = 0;
  int     tally_writes = 0;

  always #5 clk = ~clk;

  stepper_controller #(.HS_REPEAT(HS)) dut (
    .clk(clk), .reset_n(reset_n),
    .br(fl.br), .brz(fl.brz), .addi(fl.addi), .subi(fl.subi), .sr0(fl.sr0),
    .srh0(fl.srh0), .clr(fl.clr), .mov(fl.mov), .mova(fl.mova), .movr(fl.movr),
    .movrhs(fl.movrhs), .pause(fl.pause),
    .delay_done(dd), .temp_is_positive(tp), .temp_is_negative(tn), .temp_is_zero(tz),
    .register0_is_zero(r0z),
    .write_reg_file(write_reg_file), .result_mux_select(result_mux_select),
    .op1_mux_select(op1_mux_select), .op2_mux_select(op2_mux_select),
    .start_delay_counter(start_delay_counter), .enable_delay_counter(enable_delay_counter),
    .commit_branch(commit_branch), .increment_pc(increment_pc),
    .alu_add_sub(alu_add_sub), .alu_set_low(alu_set_low), .alu_set_high(alu_set_high),
    .load_temp(load_temp), .increment_temp(increment_temp), .decrement_temp(decrement_temp),
    .select_immediate(select_immediate), .select_write_address(select_write_address)
  );

  assign dut_o = {write_reg_file, result_mux_select, op1_mux_select, op2_mux_select,
                  start_delay_counter, enable_delay_counter, commit_branch, increment_pc,
                  alu_add_sub, alu_set_low, alu_set_high, load_temp, increment_temp,
                  decrement_temp, select_immediate, select_write_address};

  // ---------------- model: expected outputs from the instruction rules ----
  function automatic outs_t o_inc();
    outs_t o = '0;
    o.inc_pc = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_branch();
    outs_t o = '0;
    o.op1 = 2'b00; o.op2 = 2'b01; o.sel_imm = 2'b00; o.commit = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_dec(input flags_t f, input logic z);
    outs_t o = '0;
    if (f.br) o = o_branch();
    else if (f.brz) o = z ? o_branch() : o_inc();
    else if (f.addi || f.subi) begin
      o = o_inc(); o.op1 = 2'b01; o.op2 = 2'b01; o.sel_imm = 2'b01;
      o.add_sub = f.subi; o.wr = 1'b1; o.wr_addr = 2'b00;
    end else if (f.sr0 || f.srh0) begin
      o = o_inc(); o.op1 = 2'b10; o.op2 = 2'b01; o.sel_imm = 2'b10;
      o.set_low = f.sr0; o.set_high = !f.sr0; o.wr = 1'b1; o.wr_addr = 2'b10;
    end else if (f.clr) begin
      o = o_inc(); o.op1 = 2'b01; o.op2 = 2'b10; o.set_low = 1'b1; o.set_high = 1'b1;
      o.wr = 1'b1; o.wr_addr = 2'b00;
    end else if (f.mov) begin
      o = o_inc(); o.op1 = 2'b01; o.op2 = 2'b10; o.wr = 1'b1; o.wr_addr = 2'b01;
    end else if (f.mova) begin
      o.op1 = 2'b01; o.op2 = 2'b10; o.wr = 1'b1; o.wr_addr = 2'b11;
    end else if (f.movr || f.movrhs) o.load_temp = 1'b1;
    else if (f.pause) o = '0;
    else o = o_inc();
    return o;
  endfunction

  function automatic outs_t o_step(input logic neg);
    outs_t o = '0;
    o.op1 = 2'b11; o.op2 = 2'b11; o.add_sub = neg; o.wr = 1'b1; o.wr_addr = 2'b11;
    o.inc_temp = neg; o.dec_temp = !neg;
    return o;
  endfunction

  function automatic outs_t o_start();
    outs_t o = '0;
    o.start = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_wait(input logic done_pc);
    outs_t o = '0;
    o.enable = 1'b1; o.inc_pc = done_pc;
    return o;
  endfunction

  task automatic push(input string nm, input logic rn, input flags_t f, input logic d,
                      input logic [2:0] t, input logic z, input outs_t e);
    entry_t x;
    x.name = nm; x.rn = rn; x.rst_mid = 1'b0; x.f = f; x.dd = d; x.t = t; x.r0z = z;
    x.e = e; x.clr = 1'b0; x.chk = 1'b0;
    x.exp_starts = 0; x.exp_writes = 0; x.mdl_starts = 0; x.mdl_writes = 0;
    q.push_back(x);
  endtask

  task automatic gen_simple(input string nm, input flags_t f, input logic z);
    push({nm, " fetch"}, 1'b1, f, 1'b0, 3'b000, z, '0);
    push({nm, " decode"}, 1'b1, f, 1'b0, 3'b000, z, o_dec(f, z));
  endtask

  // Pause-like sequence: decode, start, then `waits` wait cycles, done on the last.
  task automatic gen_pause(input string nm, input flags_t f, input int waits, input logic early);
    gen_simple(nm, f, 1'b0);
    push({nm, " start"}, 1'b1, f, early, 3'b000, 1'b0, o_start());
    for (int i = 0; i < waits; i++)
      push($sformatf("%s wait%0d", nm, i), 1'b1, f, (i == waits - 1) ? 1'b1 : early,
           3'b000, 1'b0, o_wait(i == waits - 1));
  endtask

  // Relative move of `steps` steps in one direction, each step waiting
  // HS (high-speed) or 1 delay passes of `waits` cycles, then a zero check.
  task automatic gen_move(input string nm, input logic hs, input int steps, input logic neg,
                          input int waits);
    flags_t f = hs ? F_MOVRHS : F_MOVR;
    logic [2:0] sgn = neg ? 3'b001 : 3'b010;
    int passes = hs ? HS : 1;
    push({nm, " fetch"}, 1'b1, f, 1'b0, sgn, 1'b0, '0);
    push({nm, " decode"}, 1'b1, f, 1'b0, sgn, 1'b0, o_dec(f, 1'b0));
    for (int s = 0; s < steps; s++) begin
      push($sformatf("%s check%0d", nm, s), 1'b1, f, 1'b0, sgn, 1'b0, o_step(neg));
      for (int p = 0; p < passes; p++) begin
        push($sformatf("%s s%0d start%0d", nm, s, p), 1'b1, f, 1'b0, sgn, 1'b0, o_start());
        for (int w = 0; w < waits; w++)
          push($sformatf("%s s%0d p%0d wait%0d", nm, s, p, w), 1'b1, f, w == waits - 1,
               sgn, 1'b0, o_wait(1'b0));
      end
    end
    push({nm, " check zero"}, 1'b1, f, 1'b0, 3'b100, 1'b0, o_inc());
  endtask

  // Attach hand-computed pulse counts to the entries from `first` to the end.
  task automatic pin(input int first, input int es, input int ew);
    int ms = 0, mw = 0;
    for (int i = first; i < q.size(); i++) begin
      ms += int'(q[i].e.start);
      mw += int'(q[i].e.wr);
    end
    q[first].clr = 1'b1;
    q[q.size()-1].chk = 1'b1;
    q[q.size()-1].exp_starts = es;
    q[q.size()-1].exp_writes = ew;
    q[q.size()-1].mdl_starts = ms;
    q[q.size()-1].mdl_writes = mw;
  endtask

  task automatic run_q();
    while (q.size() > 0) begin
      cur = q.pop_front();
      reset_n = cur.rn; fl = cur.f; dd = cur.dd; {tz, tp, tn} = cur.t; r0z = cur.r0z;
      cur_valid = 1'b1;
      if (cur.rst_mid) begin
        #2;
        reset_n = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    cur_valid = 1'b0;
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Compare process: every queued cycle is checked on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cur_valid) begin
        if (cur.clr) begin
          tally_starts = 0;
          tally_writes = 0;
        end
        n_checks++;
        if (dut_o !== cur.e) begin
          n_fail++;
          $display("FAIL %s: outputs got %h expected %h", cur.name, dut_o, cur.e);
        end
        tally_starts += int'(dut_o.start);
        tally_writes += int'(dut_o.wr);
        if (cur.chk) begin
          chk_int({cur.name, " model starts"}, cur.mdl_starts, cur.exp_starts);
          chk_int({cur.name, " model writes"}, cur.mdl_writes, cur.exp_writes);
          chk_int({cur.name, " dut starts"}, tally_starts, cur.exp_starts);
          chk_int({cur.name, " dut writes"}, tally_writes, cur.exp_writes);
        end
      end
    end
  end

  initial begin
    int first;
    entry_t x;
    reset_n = 1'b0; fl = F_NONE; dd = 1'b0; tz = 1'b0; tp = 1'b0; tn = 1'b0; r0z = 1'b0;

    // Reset held with live inputs: everything must stay 0.
    push("reset br", 1'b0, F_BR, 1'b1, 3'b010, 1'b1, '0);
    push("reset movr", 1'b0, F_MOVR, 1'b1, 3'b001, 1'b1, '0);
    // nop stream: 2-cycle period with increment_pc in DECODE.
    gen_simple("nop0", F_NONE, 1'b0);
    gen_simple("nop1", F_NONE, 1'b0);
    gen_simple("br", F_BR, 1'b0);
    gen_simple("brz taken", F_BRZ, 1'b1);
    gen_simple("brz not taken", F_BRZ, 1'b0);
    gen_simple("addi", F_ADDI, 1'b0);
    gen_simple("subi", F_SUBI, 1'b0);
    gen_simple("sr0", F_SR0, 1'b0);
    gen_simple("srh0", F_SRH0, 1'b0);
    gen_simple("clr", F_CLR, 1'b0);
    gen_simple("mov", F_MOV, 1'b0);
    gen_simple("prio br>addi", F_BR | F_ADDI, 1'b0);
    gen_simple("prio brz>addi", F_BRZ | F_ADDI, 1'b0);
    gen_simple("prio subi>clr", F_SUBI | F_CLR | F_PAUSE, 1'b0);
    gen_simple("prio sr0>srh0", F_SR0 | F_SRH0, 1'b0);
    gen_simple("prio mov>mova", F_MOV | F_MOVA, 1'b0);
    // Pauses and absolute move.
    gen_pause("pause", F_PAUSE, 1, 1'b0);
    gen_pause("pause d0", F_PAUSE, 1, 1'b1);
    gen_pause("pause long", F_PAUSE, 3, 1'b0);
    gen_pause("mova", F_MOVA, 2, 1'b0);
    // Relative moves with hand-counted pulse totals.
    first = q.size(); gen_move("movr", 1'b0, 3, 1'b0, 4); pin(first, 3, 3);
    first = q.size(); gen_move("movrhs neg", 1'b1, 1, 1'b1, 2); pin(first, 2, 1);
    first = q.size(); gen_move("movrhs pos", 1'b1, 2, 1'b0, 1); pin(first, 4, 2);
    first = q.size(); gen_move("movr after hs", 1'b0, 2, 1'b1, 1); pin(first, 2, 2);
    // Reset asserted in the middle of an M_WAIT cycle.
    push("rm fetch", 1'b1, F_MOVR, 1'b0, 3'b010, 1'b0, '0);
    push("rm decode", 1'b1, F_MOVR, 1'b0, 3'b010, 1'b0, o_dec(F_MOVR, 1'b0));
    push("rm check", 1'b1, F_MOVR, 1'b0, 3'b010, 1'b0, o_step(1'b0));
    push("rm start", 1'b1, F_MOVR, 1'b0, 3'b010, 1'b0, o_start());
    push("rm wait", 1'b1, F_MOVR, 1'b0, 3'b010, 1'b0, o_wait(1'b0));
    push("rm wait reset", 1'b1, F_MOVR, 1'b0, 3'b010, 1'b0, '0);
    x = q.pop_back(); x.rst_mid = 1'b1; q.push_back(x);
    push("rm held", 1'b0, F_MOVR, 1'b1, 3'b010, 1'b0, '0);
    first = q.size(); gen_move("rm rerun", 1'b0, 1, 1'b0, 2); pin(first, 1, 1);
    gen_simple("final nop", F_NONE, 1'b0);

    @(posedge clk);
    #1;
    run_q();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
